// File: rtl/demux_lane_sequencer.sv
// demux_lane_sequencer: buffers an incoming pixel stream in a small FIFO and
// feeds the 4-way pixel demux round-robin, BURST pixels per lane, in strict
// FIFO order. A lane that is not ready stalls the head; lanes are never skipped.
module demux_lane_sequencer #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [BITS-1:0]          in_data,
    output logic                     in_ready,
    input  logic                     sof,
    input  logic [3:0]               lane_ready,
    output logic [1:0]               sel,
    output logic [BITS-1:0]          out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1;

    // Registered output stage towards the demux.
    typedef struct packed {
        logic            vld;
        logic [1:0]      sel;
        logic [BITS-1:0] data;
    } out_t;

    logic [DEPTH-1:0][BITS-1:0] mem_q, mem_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]            count_q, count_d;
    logic [1:0]                 cur_lane_q, cur_lane_d;
    logic [CW-1:0]              burst_cnt_q, burst_cnt_d;
    out_t                       out_q, out_d;

    logic                       push, pop;
    logic [1:0]                 eff_lane;
    logic [CW-1:0]              eff_cnt;

    // Acceptance depends only on the registered occupancy, never on this cycle's pop.
    assign in_ready   = (count_q < CNTW'(DEPTH));
    assign fifo_count = count_q;
    assign sel        = out_q.sel;
    assign out_data   = out_q.data;
    assign out_valid  = out_q.vld;

    // Handshake decisions; sof realigns the sequencer to lane 0 for this cycle.
    always_comb begin
        eff_lane = sof ? 2'd0 : cur_lane_q;
        eff_cnt  = sof ? '0 : burst_cnt_q;
        push     = in_valid & in_ready;
        pop      = (count_q != '0) & lane_ready[eff_lane];
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Lane/burst sequencing: advance to the next lane after BURST pops.
    always_comb begin
        cur_lane_d  = eff_lane;
        burst_cnt_d = eff_cnt;
        if (pop) begin
            if (eff_cnt == CW'(BURST - 1)) begin
                burst_cnt_d = '0;
                cur_lane_d  = eff_lane + 2'd1;
            end else begin
                burst_cnt_d = eff_cnt + CW'(1);
            end
        end
    end

    // Output register: pixel on pop, zero data otherwise; sel holds between pixels.
    always_comb begin
        out_d.vld  = pop;
        out_d.sel  = pop ? eff_lane : out_q.sel;
        out_d.data = pop ? mem_q[rd_ptr_q] : '0;
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_lane_q  <= '0;
            burst_cnt_q <= '0;
            out_q       <= '0;
        end else begin
            cur_lane_q  <= cur_lane_d;
            burst_cnt_q <= burst_cnt_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_demux_lane_sequencer.sv
// Bench for demux_lane_sequencer: hand-computed per-cycle vector table for the
// directed corner cases, then a random stream checked against a scoreboard queue.
module tb_demux_lane_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = '0;
    logic       in_ready;
    logic       sof = 1'b0;
    logic [3:0] lane_ready = '0;
    logic [1:0] sel;
    logic [1:0] out_data;
    logic       out_valid;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    demux_lane_sequencer #(.BITS(2), .DEPTH(4), .BURST(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sof(sof), .lane_ready(lane_ready), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // One row: inputs applied before a rising edge, outputs expected after it.
    typedef struct {
        int rst, iv, id, sof, lr;
        int e_rdy, e_ov, e_sel, e_dat, e_cnt;
        string tag;
    } vec_t;

    typedef struct {
        int data;
        int sel;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic add(input string tag, input int r, iv, id, s, lr,
                       input int er, eo, es, ed, ec);
        vec_t v;
        v.tag = tag; v.rst = r; v.iv = iv; v.id = id; v.sof = s; v.lr = lr;
        v.e_rdy = er; v.e_ov = eo; v.e_sel = es; v.e_dat = ed; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sof = 1'b0; lane_ready = '0;
        @(posedge clk);
        #1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // A: two bursts of four, all lanes ready.
        add("A_rst", 1, 0, 0, 0, 'hF, 1, 0, 0, 0, 0);
        add("A1", 0, 1, 0, 0, 'hF, 1, 0, 0, 0, 1);
        add("A2", 0, 1, 1, 0, 'hF, 1, 1, 0, 0, 1);
        add("A3", 0, 1, 2, 0, 'hF, 1, 1, 0, 1, 1);
        add("A4", 0, 1, 3, 0, 'hF, 1, 1, 0, 2, 1);
        add("A5", 0, 1, 0, 0, 'hF, 1, 1, 0, 3, 1);
        add("A6", 0, 1, 1, 0, 'hF, 1, 1, 1, 0, 1);
        add("A7", 0, 1, 2, 0, 'hF, 1, 1, 1, 1, 1);
        add("A8", 0, 1, 3, 0, 'hF, 1, 1, 1, 2, 1);
        add("A9", 0, 0, 0, 0, 'hF, 1, 1, 1, 3, 0);
        add("A10", 0, 0, 0, 0, 'hF, 1, 0, 1, 0, 0);
        // B: fill to full with no lane ready, then drain through lane 0, stall on lane 1.
        add("B_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add("B1", 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
        add("B2", 0, 1, 2, 0, 0, 1, 0, 0, 0, 2);
        add("B3", 0, 1, 3, 0, 0, 1, 0, 0, 0, 3);
        add("B4", 0, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        add("B5", 0, 1, 1, 0, 0, 0, 0, 0, 0, 4);
        add("B6", 0, 1, 1, 0, 1, 1, 1, 0, 1, 3);
        add("B7", 0, 1, 1, 0, 1, 1, 1, 0, 2, 3);
        add("B8", 0, 0, 0, 0, 1, 1, 1, 0, 3, 2);
        add("B9", 0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
        add("B10", 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        add("B11", 0, 0, 0, 0, 2, 1, 1, 1, 1, 0);
        // C: sof with a pop after two lane-0 pops, then sof without a pop.
        add("C_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add("C1", 0, 1, 1, 0, 'hF, 1, 0, 0, 0, 1);
        add("C2", 0, 1, 2, 0, 'hF, 1, 1, 0, 1, 1);
        add("C3", 0, 1, 3, 0, 'hF, 1, 1, 0, 2, 1);
        add("C4", 0, 1, 0, 1, 'hF, 1, 1, 0, 3, 1);
        add("C5", 0, 1, 1, 0, 'hF, 1, 1, 0, 0, 1);
        add("C6", 0, 1, 2, 0, 'hF, 1, 1, 0, 1, 1);
        add("C7", 0, 1, 3, 0, 'hF, 1, 1, 0, 2, 1);
        add("C8", 0, 0, 0, 0, 'hF, 1, 1, 1, 3, 0);
        add("C9", 0, 0, 0, 1, 'hF, 1, 0, 1, 0, 0);
        add("C10", 0, 1, 2, 0, 0, 1, 0, 1, 0, 1);
        add("C11", 0, 0, 0, 0, 'hF, 1, 1, 0, 2, 0);
        // D: lane 2 busy when its turn comes; pixel k carries (k-1)%4.
        add("D_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add("D1", 0, 1, 0, 0, 'hF, 1, 0, 0, 0, 1);
        for (int i = 2; i <= 9; i++)
            add($sformatf("D%0d", i), 0, 1, (i - 1) % 4, 0, 'hF, 1, 1, (i - 2) / 4, (i - 2) % 4, 1);
        add("D10", 0, 1, 1, 0, 'hB, 1, 0, 1, 0, 2);
        add("D11", 0, 0, 0, 0, 'hB, 1, 0, 1, 0, 2);
        add("D12", 0, 0, 0, 0, 'hF, 1, 1, 2, 0, 1);
        add("D13", 0, 0, 0, 0, 'hF, 1, 1, 2, 1, 0);
        // E: reset in the middle of lane 1's burst with three pixels queued.
        add("E_rst", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add("E1", 0, 1, 0, 0, 'hF, 1, 0, 0, 0, 1);
        for (int i = 2; i <= 6; i++)
            add($sformatf("E%0d", i), 0, 1, (i - 1) % 4, 0, 'hF, 1, 1, (i - 2) / 4, (i - 2) % 4, 1);
        add("E7", 0, 1, 2, 0, 0, 1, 0, 1, 0, 2);
        add("E8", 0, 1, 3, 0, 0, 1, 0, 1, 0, 3);
        add("E9", 1, 1, 0, 0, 'hF, 1, 0, 0, 0, 0);
        add("E10", 0, 1, 1, 0, 'hF, 1, 0, 0, 0, 1);
        add("E11", 0, 0, 0, 0, 2, 1, 0, 0, 0, 1);
        add("E12", 0, 0, 0, 0, 'hF, 1, 1, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst        = tbl[i].rst[0];
            in_valid   = tbl[i].iv[0];
            in_data    = 2'(tbl[i].id);
            sof        = tbl[i].sof[0];
            lane_ready = 4'(tbl[i].lr);
            @(posedge clk);
            #1;
            chk({tbl[i].tag, ".in_ready"},  int'(in_ready),   tbl[i].e_rdy);
            chk({tbl[i].tag, ".out_valid"}, int'(out_valid),  tbl[i].e_ov);
            chk({tbl[i].tag, ".sel"},       int'(sel),        tbl[i].e_sel);
            chk({tbl[i].tag, ".out_data"},  int'(out_data),   tbl[i].e_dat);
            chk({tbl[i].tag, ".count"},     int'(fifo_count), tbl[i].e_cnt);
        end

        // Random stream: 40 pixels (several pointer wraps, lanes wrap past 3),
        // random valid gaps and lane stalls; expected lane follows pixel index.
        do_reset();
        begin
            int sent = 0;
            int cyc  = 0;
            exp_t e;
            while ((sent < 40 || sb.size() != 0) && cyc < 3000) begin
                @(negedge clk);
                in_valid   = (sent < 40) && ($urandom_range(0, 3) != 0);
                in_data    = 2'($urandom_range(0, 3));
                lane_ready = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                sof        = 1'b0;
                if (in_valid && in_ready) begin
                    e.data = int'(in_data);
                    e.sel  = (sent / 4) % 4;
                    sb.push_back(e);
                    sent++;
                end
                @(posedge clk);
                #1;
                cyc++;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_pixel", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_data", int'(out_data), e.data);
                        chk("sb_sel",  int'(sel),      e.sel);
                    end
                end else begin
                    chk("sb_idle_data", int'(out_data), 0);
                end
            end
            chk("sb_finished_in_budget", int'(cyc < 3000), 1);
            chk("sb_all_sent", sent, 40);
            chk("sb_queue_empty", sb.size(), 0);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("sb_final_count", int'(fifo_count), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
